// File: rtl/fpc_tx_sched_if.sv
// Handshake bundle between the core-side word source, the FPC transmit
// scheduler and the 5-wire link sink.
//   master : environment side (drives the source word and the sink ready)
//   slave  : scheduler side (accepts words, drives codewords)
interface fpc_tx_sched_if #(
  parameter int WORD_W = 16
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [4:0]        out_code;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_last
  );
endinterface

// File: rtl/fpc_tx_sched.sv
// FPC transmit scheduler: takes a WORD_W-bit word, slices it into 4-bit
// nibbles (nibble 0 = bits [3:0]) and sends one 5-bit forbidden-pattern
// codeword per beat over a valid/ready link. Back-to-back words are
// accepted on the final beat with no bubble.
// Optional feature macro: FPC_IDLE_HOLD_EN -- when defined, the link wires
// keep the last sent codeword while no beat is valid instead of dropping
// to 00000, so the bus does not toggle between words.
module fpc_tx_sched #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fpc_tx_sched_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int NIB   = WORD_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // 4b->5b forbidden-pattern code: no codeword contains 010 or 101, and the
  // table is complement-symmetric (code(~n) == ~code(n)).
  function automatic logic [4:0] fpc_enc(input logic [3:0] nib);
    logic [4:0] code;
    case (nib)
      4'h0:    code = 5'b00000;
      4'h1:    code = 5'b00001;
      4'h2:    code = 5'b00110;
      4'h3:    code = 5'b00011;
      4'h4:    code = 5'b01100;
      4'h5:    code = 5'b00111;
      4'h6:    code = 5'b01110;
      4'h7:    code = 5'b01111;
      4'h8:    code = 5'b10000;
      4'h9:    code = 5'b10001;
      4'hA:    code = 5'b11000;
      4'hB:    code = 5'b10011;
      4'hC:    code = 5'b11100;
      4'hD:    code = 5'b11001;
      4'hE:    code = 5'b11110;
      4'hF:    code = 5'b11111;
      default: code = 5'b00000;
    endcase
    return code;
  endfunction

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_word;
  logic [4:0]        r_last;
  logic [CNT_W-1:0]  r_cnt;

  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [WORD_W-1:0] w_word_nxt;
  logic [4:0]        w_last_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_is_last;
  logic [3:0]        w_nib;
  logic [4:0]        w_code;

  // Current nibble and its codeword; idx never exceeds NIB-1 so the select stays in range.
  assign w_nib     = r_word[{r_idx, 2'b00} +: 4];
  assign w_code    = fpc_enc(w_nib);
  assign w_is_last = (r_idx == LAST_IDX);

  // Next-state, handshake and bookkeeping logic for the IDLE/SEND sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_word_nxt  = bus.in_data;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_out_valid = 1'b1;
        // Only path from an input (out_ready) to an output (in_ready).
        w_in_ready  = w_is_last & bus.out_ready;
        if (bus.out_ready) begin
          w_last_nxt = w_code;
          if (w_is_last) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_idx_nxt = '0;
            if (bus.in_valid) begin
              w_word_nxt  = bus.in_data;
              w_state_nxt = ST_SEND;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_word  <= '0;
      r_last  <= 5'b00000;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Link-side code mux: the valid codeword, or the idle pattern between words.
  always_comb begin
    if (w_out_valid) begin
      bus.out_code = w_code;
    end else begin
`ifdef FPC_IDLE_HOLD_EN
      bus.out_code = r_last;
`else
      bus.out_code = 5'b00000;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_valid & w_is_last;
  assign busy          = (r_state == ST_SEND);
  assign word_cnt      = r_cnt;

endmodule

// File: tb/tb_fpc_tx_sched.sv
// Bench for fpc_tx_sched: directed scenarios followed by a randomized run
// compared against a queue-of-expected-beats reference model.
module tb_fpc_tx_sched;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;   // narrow so the wrap of word_cnt is reached

  typedef struct {
    logic [4:0] code;
    logic       last;
  } beat_t;

  logic clk;
  logic rst_n;
  logic busy;
  logic [CNT_W-1:0] word_cnt;

  int errors = 0;
  int checks = 0;

  logic [4:0] enc_tbl [16] = '{
    5'b00000, 5'b00001, 5'b00110, 5'b00011,
    5'b01100, 5'b00111, 5'b01110, 5'b01111,
    5'b10000, 5'b10001, 5'b11000, 5'b10011,
    5'b11100, 5'b11001, 5'b11110, 5'b11111
  };

  logic [CNT_W-1:0] exp_cnt;
  logic [4:0]       last_sent;
  beat_t            q [$];

  fpc_tx_sched_if #(.WORD_W(WORD_W)) bus ();

  fpc_tx_sched #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] enc_of(input logic [15:0] w, input int b);
    logic [15:0] s;
    s = w >> (4 * b);
    return enc_tbl[s[3:0]];
  endfunction

  function automatic logic [4:0] idle_code();
`ifdef FPC_IDLE_HOLD_EN
    return last_sent;
`else
    return 5'b00000;
`endif
  endfunction

  // Drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] w, input int b);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_code"},  bus.out_code,  enc_of(w, b));
    chk({tag, "_last"},  bus.out_last,  (b == 3));
    chk({tag, "_busy"},  busy,          1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"},  busy,          0);
    chk({tag, "_code"},  bus.out_code,  idle_code());
    chk({tag, "_cnt"},   word_cnt,      exp_cnt);
    chk({tag, "_inrdy"}, bus.in_ready,  1);
  endtask

  initial begin
    logic v, r, exp_rdy;
    logic [15:0] d;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0000;
    bus.out_ready = 1'b0;
    exp_cnt = '0;
    last_sent = 5'b00000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_code", bus.out_code, 5'b00000);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word 1234: 01100, 00011, 00110, 00001
    cyc(1'b1, 16'h1234, 1'b1);
    chk("w1_accept_rdy", bus.in_ready, 1);
    for (int b = 0; b < 4; b++) begin
      cyc(1'b0, 16'h0000, 1'b1);
      chk_beat("w1", 16'h1234, b);
      chk("w1_inrdy", bus.in_ready, (b == 3));
    end
    chk("w1_b0_const", enc_of(16'h1234, 0), 5'b01100);
    last_sent = enc_of(16'h1234, 3);
    exp_cnt++;
    cyc(1'b0, 16'h0000, 1'b1);
    chk_idle("w1_done");

    // Back-pressure on beat 2 of A5C3; source keeps offering a word meanwhile
    cyc(1'b1, 16'hA5C3, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk_beat("bp_b0", 16'hA5C3, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 16'h1111, 1'b0);
      chk_beat("bp_stall", 16'hA5C3, 1);
      chk("bp_stall_code", bus.out_code, 5'b11100);
      chk("bp_stall_inrdy", bus.in_ready, 0);
    end
    for (int b = 1; b < 4; b++) begin
      cyc(1'b0, 16'h0000, 1'b1);
      chk_beat("bp", 16'hA5C3, b);
    end
    last_sent = enc_of(16'hA5C3, 3);
    exp_cnt++;
    cyc(1'b0, 16'h0000, 1'b1);
    chk_idle("bp_done");

    // Back-to-back 0001 then FFFF with in_valid held high
    cyc(1'b1, 16'h0001, 1'b1);
    for (int b = 0; b < 4; b++) begin
      cyc(1'b1, 16'hFFFF, 1'b1);
      chk_beat("b2b_w0", 16'h0001, b);
      chk("b2b_w0_inrdy", bus.in_ready, (b == 3));
    end
    exp_cnt++;
    for (int b = 0; b < 4; b++) begin
      cyc(1'b0, 16'h0000, 1'b1);
      chk_beat("b2b_w1", 16'hFFFF, b);
    end
    exp_cnt++;
    last_sent = 5'b11111;
    cyc(1'b0, 16'h0000, 1'b1);
    chk_idle("b2b_done");
    cyc(1'b0, 16'h0000, 1'b1);
    chk_idle("hold_idle");

    // Reset in the middle of a word
    cyc(1'b1, 16'hBEEF, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk_beat("mid_b0", 16'hBEEF, 0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk_beat("mid_b1", 16'hBEEF, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    last_sent = 5'b00000;
    chk_idle("mid_rst");
    @(negedge clk);
    chk("mid_rst_held_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    cyc(1'b1, 16'h000F, 1'b1);
    for (int b = 0; b < 4; b++) begin
      cyc(1'b0, 16'h0000, 1'b1);
      chk_beat("post_rst", 16'h000F, b);
    end
    last_sent = 5'b00000;
    exp_cnt++;
    cyc(1'b0, 16'h0000, 1'b1);
    chk_idle("post_rst_done");

    // Randomized traffic against the beat-queue model
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 16'($urandom);
      r = ($urandom_range(0, 3) != 0);
      cyc(v, d, r);
      exp_rdy = (q.size() == 0) || ((q.size() == 1) && r);
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      chk("rnd_out_valid", bus.out_valid, (q.size() != 0));
      chk("rnd_word_cnt", word_cnt, exp_cnt);
      if (q.size() != 0) begin
        chk("rnd_code", bus.out_code, q[0].code);
        chk("rnd_last", bus.out_last, q[0].last);
      end else begin
        chk("rnd_idle_code", bus.out_code, idle_code());
      end
      if ((q.size() != 0) && r) begin
        last_sent = q[0].code;
        if (q[0].last) exp_cnt++;
        void'(q.pop_front());
      end
      if (v && exp_rdy) begin
        for (int b = 0; b < 4; b++) begin
          q.push_back('{enc_of(d, b), (b == 3)});
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
